// File: rtl/ball_render.sv
// Pixel stage after ball_gen: latches the ball position once per frame and renders a filled disc.
// Three pix_en-gated pipeline stages keep rgb and syncs aligned; move is a per-frame strobe.
module ball_render #(
    parameter int unsigned width       = 1024,
    parameter int unsigned height      = 768,
    parameter int unsigned h_total     = 1344,
    parameter int unsigned v_total     = 806,
    parameter int unsigned ball_radius = 8,
    parameter logic [11:0] ball_color  = 12'hF00,
    parameter logic [11:0] bg_color    = 12'h000,
    parameter int unsigned frame_div   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pix_en,
    input  logic [$clog2(h_total)-1:0]   h_cnt,
    input  logic [$clog2(v_total)-1:0]   v_cnt,
    input  logic                         video_on,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic [$clog2(width)-1:0]     ball_x,
    input  logic [$clog2(height)-1:0]    ball_y,
    output logic                         move,
    output logic [11:0]                  rgb,
    output logic                         hsync_out,
    output logic                         vsync_out
);

    localparam int HW   = $clog2(h_total);
    localparam int VW   = $clog2(v_total);
    localparam int XW   = $clog2(width);
    localparam int YW   = $clog2(height);
    localparam int DXW  = ((HW > XW) ? HW : XW) + 1;
    localparam int DYW  = ((VW > YW) ? VW : YW) + 1;
    localparam int SQW  = 2 * ((DXW > DYW) ? DXW : DYW);
    localparam int SUMW = SQW + 1;
    localparam int FW   = (frame_div > 1) ? $clog2(frame_div) : 1;
    localparam logic [SUMW-1:0] R2 = SUMW'(ball_radius * ball_radius);
    localparam logic [FW-1:0]   FLAST = FW'(frame_div - 1);

    logic [XW-1:0]         sx_q;
    logic [YW-1:0]         sy_q;
    logic [FW-1:0]         frame_cnt_q;
    logic signed [DXW-1:0] dx_q;
    logic signed [DYW-1:0] dy_q;
    logic                  von1_q, hs1_q, vs1_q;
    logic [SQW-1:0]        dx2_q, dy2_q;
    logic                  von2_q, hs2_q, vs2_q;

    logic                  frame_start, move_line;
    logic [XW-1:0]         cur_x;
    logic [YW-1:0]         cur_y;
    logic signed [DXW-1:0] dx_d;
    logic signed [DYW-1:0] dy_d;
    logic [SUMW-1:0]       dist2;
    logic                  hit;

    always_comb begin
        frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);
        move_line   = pix_en && (h_cnt == '0) && (v_cnt == VW'(height));
        // Pixel (0,0) already uses the newly latched position so the whole frame is consistent.
        cur_x = frame_start ? ball_x : sx_q;
        cur_y = frame_start ? ball_y : sy_q;
        dx_d  = $signed(DXW'(h_cnt)) - $signed(DXW'(cur_x));
        dy_d  = $signed(DYW'(v_cnt)) - $signed(DYW'(cur_y));
        dist2 = {1'b0, dx2_q} + {1'b0, dy2_q};
        hit   = (dist2 <= R2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx_q        <= '0;
            sy_q        <= '0;
            frame_cnt_q <= '0;
            move        <= 1'b0;
        end else begin
            move <= 1'b0;
            if (frame_start) begin
                sx_q <= ball_x;
                sy_q <= ball_y;
            end
            if (move_line) begin
                if (frame_cnt_q == FLAST) begin
                    frame_cnt_q <= '0;
                    move        <= 1'b1;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx_q      <= '0;
            dy_q      <= '0;
            von1_q    <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            dx2_q     <= '0;
            dy2_q     <= '0;
            von2_q    <= 1'b0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            rgb       <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else if (pix_en) begin
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            von1_q    <= video_on;
            hs1_q     <= hsync_in;
            vs1_q     <= vsync_in;
            dx2_q     <= dx_q * dx_q;
            dy2_q     <= dy_q * dy_q;
            von2_q    <= von1_q;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            rgb       <= !von2_q ? 12'h000 : (hit ? ball_color : bg_color);
            hsync_out <= hs2_q;
            vsync_out <= vs2_q;
        end
    end

endmodule
